// File: rtl/reg_file_clr.sv
// reg_file_clr: 2**ADDR_W x WIDTH register file; a full clear runs after every reset and busy stays high meanwhile. Ports: clk, rst (sync, active-high), ra1/ra2 -> rd1/rd2 (combinational reads), wa/wd/we (write port), busy (clear in progress). Optional write-to-read bypass under REG_FILE_BYPASS_EN.
module reg_file_clr #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              we,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              busy
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_idx, clr_idx_n;
  logic [WIDTH-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_n;
      clr_idx <= clr_idx_n;
      busy    <= state_n == CLEAR;
    end
  end
  // The clear ends on the last index; READY is absorbing until the next reset.
  always_comb begin
    state_n   = (state == CLEAR && &clr_idx) ? READY : state;
    clr_idx_n = (state == CLEAR) ? clr_idx + ADDR_W'(1) : clr_idx;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_idx] <= '0;
      else if (we && wa != '0) mem[wa] <= wd;
    end
  end
`ifdef REG_FILE_BYPASS_EN
  logic wr;
  assign wr  = !busy && we && wa != '0;
  assign rd1 = (busy || ra1 == '0) ? '0 : (wr && ra1 == wa) ? wd : mem[ra1];
  assign rd2 = (busy || ra2 == '0) ? '0 : (wr && ra2 == wa) ? wd : mem[ra2];
`else
  assign rd1 = (busy || ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (busy || ra2 == '0) ? '0 : mem[ra2];
`endif
endmodule

// File: tb/tb_reg_file_clr.sv
// tb_reg_file_clr: directed scoreboard bench for reg_file_clr
module tb_reg_file_clr;
  logic clk = 0, rst = 0, we = 0, busy;
  logic [4:0] ra1 = 0, ra2 = 0, wa = 0;
  logic [31:0] wd = 0, rd1, rd2;
  int vectors = 0, errors = 0, n;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t sb[$];

  reg_file_clr dut (.clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .wa(wa), .wd(wd), .we(we),
                    .rd1(rd1), .rd2(rd2), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic push(string tag, int sel, logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    #1;
    while (sb.size() > 0) begin
      exp_t e = sb.pop_front();
      chk(e.tag, e.sel == 0 ? rd1 : e.sel == 1 ? rd2 : {31'b0, busy}, e.exp);
    end
  endtask

  task automatic count_clear(string tag);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      we = 1; wa = 3; wd = 32'h55;
      push({tag, "_rd1"}, 0, 0);
      push({tag, "_rd2"}, 1, 0);
      drain();
      n++;
      tick();
    end
    we = 0;
    chk({tag, "_len"}, n, 32);
    push({tag, "_busy_low"}, 2, 0);
    drain();
  endtask

  initial begin
    rst = 1; we = 1; wa = 9; wd = 32'hDEAD;
    tick();
    rst = 0;
    push("reset_busy", 2, 1);
    drain();
    count_clear("clear1");
    ra1 = 3; ra2 = 9;
    push("busy_write_dropped", 0, 0);
    push("reset_write_dropped", 1, 0);
    drain();
    we = 1; wa = 5; wd = 32'hA5;
    tick();
    we = 0; ra1 = 5; ra2 = 0;
    push("wr5_rd1", 0, 32'hA5);
    push("wr5_rd2_zero", 1, 0);
    drain();
    we = 1; wa = 0; wd = 32'hFFFF_FFFF; ra1 = 0; ra2 = 5;
    push("wr0_same_cycle", 0, 0);
    drain();
    tick();
    we = 0;
    push("wr0_discard", 0, 0);
    push("wr0_no_alias", 1, 32'hA5);
    drain();
    we = 1; wa = 7; wd = 32'h1234_5678; ra1 = 5; ra2 = 7;
`ifdef REG_FILE_BYPASS_EN
    push("bypass_pre_edge", 1, 32'h1234_5678);
`else
    push("no_bypass_pre_edge", 1, 0);
`endif
    push("other_port", 0, 32'hA5);
    drain();
    tick();
    we = 0;
    push("wr7_post_edge", 1, 32'h1234_5678);
    drain();
    ra1 = 7; ra2 = 7;
    push("same_addr_p1", 0, 32'h1234_5678);
    push("same_addr_p2", 1, 32'h1234_5678);
    drain();
    for (int i = 1; i < 32; i++) begin
      we = 1; wa = 5'(i); wd = i;
      tick();
    end
    we = 0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      push($sformatf("fill_rd1_%0d", i), 0, i);
      push($sformatf("fill_rd2_%0d", i), 1, 31 - i);
      drain();
    end
    rst = 1;
    tick();
    rst = 0;
    repeat (10) tick();
    rst = 1;
    tick();
    rst = 0;
    count_clear("clear2");
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      push($sformatf("post_clr_rd1_%0d", i), 0, 0);
      push($sformatf("post_clr_rd2_%0d", i), 1, 0);
      drain();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_clr.md
REG_FILE_CLR -- requirements
Module: reg_file_clr

Interface
REQ-001 Parameter: WIDTH, 32, data width of every register and of the read/write data ports.
REQ-002 Parameter: ADDR_W, 5, register address width; the array holds 2**ADDR_W entries.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ra1  input  ADDR_W  read address, port 1; its data feeds the ALU operand a.
REQ-006 ra2  input  ADDR_W  read address, port 2; its data feeds the ALU operand b.
REQ-007 wa  input  ADDR_W  write address.
REQ-008 wd  input  WIDTH  write data, normally the ALU result.
REQ-009 we  input  1  write enable.
REQ-010 rd1  output  WIDTH  read data, port 1.
REQ-011 rd2  output  WIDTH  read data, port 2.
REQ-012 busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-013 The block SHALL have two states: CLEAR and READY.
REQ-014 In CLEAR, a counter clr_idx SHALL start at 0, write zero to entry clr_idx each cycle, and increment by 1.
REQ-015 CLEAR SHALL last exactly 2**ADDR_W cycles (32 by default); the cycle after entry 31 is cleared, the block SHALL be in READY.
REQ-016 busy SHALL be 1 in CLEAR and 0 in READY, registered; it SHALL NOT glitch.
REQ-017 While busy=1: we SHALL be ignored; rd1 and rd2 SHALL read 0.
REQ-018 In READY with we=1 and wa!=0, wd SHALL be stored into entry wa at the rising edge.
REQ-019 Entry 0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-020 Reads SHALL be combinational, with zero-cycle latency: rd1 = entry[ra1] and rd2 = entry[ra2].
REQ-021 If ra1 and ra2 are equal, both ports SHALL return the same value.
REQ-022 Writes to one entry SHALL never alter any other entry.
REQ-023 The counter SHALL NOT wrap back into CLEAR; READY SHALL persist until the next rst.

Reset
REQ-024 rst=1 at a rising edge SHALL force the state to CLEAR, clr_idx to 0, and busy to 1 on the following cycle.
REQ-025 rst asserted mid-CLEAR SHALL restart the sequence from index 0.
REQ-026 rst asserted in READY SHALL discard any coincident write and begin a new full clear.
REQ-027 Array contents SHALL be undefined only until each entry is cleared; reads return 0 throughout, per REQ-017.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-029 With REG_FILE_BYPASS_EN defined, in READY with we=1, wa!=0 and ra1==wa (or ra2==wa), the matching port SHALL return wd in the same cycle.
REQ-030 Without REG_FILE_BYPASS_EN, the matching port SHALL return the stored old value until the edge, and the new value after it.
REQ-031 Bypass SHALL never apply to address 0 or while busy=1.

Verification
REQ-032 Assert rst for 1 cycle, then release -> busy=1 for exactly 32 cycles, then 0; rd1 and rd2 read 0 throughout.
REQ-033 In READY: write wa=5, wd=0x0000_00A5, then set ra1=5 and ra2=0 -> rd1=0x0000_00A5 and rd2=0.
REQ-034 Write wa=0, wd=0xFFFF_FFFF -> reading ra1=0 returns 0.
REQ-035 Same-cycle write wa=7, wd=0x1234_5678 with ra2=7 -> rd2=0x1234_5678 before the edge only if REG_FILE_BYPASS_EN is defined; otherwise rd2 keeps its old value until after the edge.
REQ-036 Fill entries 1..31 with their index values, assert rst for 1 cycle at clear index 10, then rerun -> busy lasts 32 cycles from the reassertion and every entry reads 0 afterwards.
REQ-037 Assert we=1, wa=3, wd=0x55 while busy=1 -> after READY, entry 3 reads 0.
